popcount_pipe: RTL and testbench
================================

POPCOUNT_PIPE -- requirements
Module: popcount_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the input word width; legal values are multiples of 8 from 8 to 256.
REQ-002 The block SHALL have parameter ACC_W, default 32, giving the COUNT and WORDS width; legal values are ACC_W >= $clog2(DATA_W+1).
REQ-003 The block SHALL have port ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port ARESET, input, 1 bit: the reset, synchronous and active-high.
REQ-005 The block SHALL have port WRITE_DATA, input, DATA_W bits: the word to count.
REQ-006 The block SHALL have port WRITE_VALID, input, 1 bit: WRITE_DATA is valid.
REQ-007 The block SHALL have port WRITE_READY, output, 1 bit: the block accepts the word this cycle.
REQ-008 The block SHALL have port COUNT_RST, input, 1 bit: synchronous clear of the accumulation and flush of the pipeline.
REQ-009 The block SHALL have port COUNT, output, ACC_W bits: the accumulated number of set bits.
REQ-010 The block SHALL have port WORDS, output, ACC_W bits: the number of words accumulated since the last clear.
REQ-011 The block SHALL have port OVERFLOW, output, 1 bit: sticky flag, set when COUNT exceeded its range.
REQ-012 The block SHALL have port COUNT_BUSY, output, 1 bit: high while any accepted word has not yet reached COUNT.

Function
REQ-013 A word SHALL be accepted on a rising edge where WRITE_VALID and WRITE_READY are both 1; at no other time.
REQ-014 WRITE_READY SHALL be 1 except while ARESET or COUNT_RST is 1; it is combinational from those inputs only, and never from WRITE_VALID.
REQ-015 Pipeline stage S1 SHALL register the per-byte popcounts (DATA_W/8 values, 4 bits each) on the acceptance edge k.
REQ-016 Stage S2 SHALL register the word sum of the S1 byte counts, $clog2(DATA_W+1) bits wide, on edge k+1.
REQ-017 Stage S3 SHALL add the S2 sum into COUNT and increment WORDS by 1 on edge k+2; fixed latency 3 edges, throughput 1 word per cycle.
REQ-018 Each stage SHALL carry a valid bit; a stage with a cleared valid bit contributes nothing.
REQ-019 COUNT_BUSY SHALL equal S1 valid OR S2 valid.
REQ-020 COUNT_RST=1 on an edge SHALL zero COUNT, WORDS and OVERFLOW and clear all stage valid bits, discarding in-flight words.
REQ-021 If COUNT_RST and WRITE_VALID are both 1 in the same cycle, the word SHALL NOT be accepted, because WRITE_READY is 0.
REQ-022 When COUNT plus the S2 sum carries past 2^ACC_W-1, OVERFLOW SHALL be set and remain set until COUNT_RST or ARESET.
REQ-023 WORDS SHALL wrap modulo 2^ACC_W and SHALL NOT affect OVERFLOW.
REQ-024 A word of all zeros SHALL be accepted and increment WORDS, and SHALL leave COUNT unchanged.

Reset
REQ-025 ARESET=1 on an edge SHALL force COUNT=0, WORDS=0, OVERFLOW=0, all valid bits=0 and COUNT_BUSY=0.
REQ-026 ARESET SHALL take priority over COUNT_RST and over acceptance; reset mid-stream discards all in-flight words.
REQ-027 WRITE_READY SHALL be 0 while ARESET is 1, and SHALL be 1 on the first cycle after ARESET is released (provided COUNT_RST=0).

Configuration
REQ-028 The macro POPCOUNT_SAT_EN SHALL select the overflow behaviour of COUNT.
REQ-029 With POPCOUNT_SAT_EN defined, on overflow COUNT SHALL clamp to 2^ACC_W-1 and hold there, and OVERFLOW SHALL be set.
REQ-030 Without POPCOUNT_SAT_EN, COUNT SHALL wrap modulo 2^ACC_W, and OVERFLOW SHALL be set all the same.

Structure
REQ-031 Package popcount_pkg SHALL hold the byte-count width constant (4), a byte-popcount function, and a stage-valid record typedef.
REQ-032 Sub-module popcount_tree SHALL implement S1 and S2: a DATA_W-bit word in, a registered sum out, with its own valid bit.
REQ-033 popcount_pipe SHALL instantiate popcount_tree once and hold S3, the handshake and the flags.

Verification
REQ-034 After ARESET, WRITE_DATA=0xFFFFFFFF with WRITE_VALID=1 for 1 cycle -> COUNT=32, WORDS=1 three edges later, and COUNT_BUSY high for exactly 2 cycles.
REQ-035 Back-to-back 0x0000000F, 0x80000001, 0x00000000 -> COUNT goes 4, 6, 6 and WORDS goes 1, 2, 3 on consecutive edges.
REQ-036 COUNT_RST pulsed while 2 words are in flight -> COUNT=0, WORDS=0, BUSY=0 next cycle; the discarded words never appear; WRITE_READY=0 during the pulse.
REQ-037 With ACC_W=6, DATA_W=32, three words 0xFFFFFFFF -> OVERFLOW=1; COUNT=63 with POPCOUNT_SAT_EN, COUNT=32 without it.
REQ-038 With DATA_W=64, word 0xAAAAAAAAAAAAAAAA -> COUNT=32; then ARESET mid-stream -> all outputs 0, and WRITE_READY=1 on the cycle after release.

Source files
------------

// File: rtl/popcount_pkg.sv
// Shared constants, byte popcount helper and stage-valid record for popcount_pipe.
package popcount_pkg;

   localparam int BYTE_CNT_W = 4;

   typedef struct packed {
      logic s1;
      logic s2;
   } stage_valid_t;

   function automatic logic [BYTE_CNT_W-1:0] byte_popcount(input logic [7:0] b);
      logic [BYTE_CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, b[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/popcount_tree.sv
// Two-stage popcount tree: S1 registers per-byte counts, S2 registers their word sum.
module popcount_tree
   import popcount_pkg::*;
#(
   parameter int DATA_W = 32,
   localparam int SUM_W = $clog2(DATA_W + 1)
) (
   input  logic              clk_i,
   input  logic              clr_i,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              s1_valid_o,
   output logic              s2_valid_o,
   output logic [SUM_W-1:0]  sum_o
);

   localparam int NB = DATA_W / 8;

   logic [NB-1:0][BYTE_CNT_W-1:0] byte_cnt_d;
   logic [NB-1:0][BYTE_CNT_W-1:0] byte_cnt_q;
   logic [SUM_W-1:0]              sum_d;
   logic [SUM_W-1:0]              sum_q;
   logic                          s1_valid_q;
   logic                          s2_valid_q;

   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_byte
         assign byte_cnt_d[gi] = byte_popcount(in_data_i[gi*8 +: 8]);
      end
   endgenerate

   always_comb begin
      sum_d = '0;
      for (int i = 0; i < NB; i++) begin
         sum_d = sum_d + SUM_W'(byte_cnt_q[i]);
      end
   end

   // Data registers only load on valid; the valid bits alone decide what counts.
   always_ff @(posedge clk_i) begin
      if (in_valid_i) begin
         byte_cnt_q <= byte_cnt_d;
      end
      if (s1_valid_q) begin
         sum_q <= sum_d;
      end
      if (clr_i) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= in_valid_i;
         s2_valid_q <= s1_valid_q;
      end
   end

   assign s1_valid_o = s1_valid_q;
   assign s2_valid_o = s2_valid_q;
   assign sum_o      = sum_q;

endmodule

// File: rtl/popcount_pipe.sv
// Pipelined popcount accumulator: tree (S1/S2), accumulate stage S3, handshake and flags.
// Define POPCOUNT_SAT_EN to make COUNT saturate on overflow instead of wrapping.
module popcount_pipe
   import popcount_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ACC_W  = 32
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic [DATA_W-1:0] WRITE_DATA,
   input  logic              WRITE_VALID,
   output logic              WRITE_READY,
   input  logic              COUNT_RST,
   output logic [ACC_W-1:0]  COUNT,
   output logic [ACC_W-1:0]  WORDS,
   output logic              OVERFLOW,
   output logic              COUNT_BUSY
);

   localparam int SUM_W = $clog2(DATA_W + 1);

   logic             clr;
   logic             accept;
   logic             s1_valid;
   logic             s2_valid;
   logic [SUM_W-1:0] sum;
   stage_valid_t     vld;
   logic [ACC_W:0]   add_w;
   logic [ACC_W-1:0] count_d, count_q;
   logic [ACC_W-1:0] words_d, words_q;
   logic             ovf_d, ovf_q;

   assign clr         = ARESET | COUNT_RST;
   assign WRITE_READY = ~clr;
   assign accept      = WRITE_VALID & WRITE_READY;

   popcount_tree #(
      .DATA_W (DATA_W)
   ) u_tree (
      .clk_i      (ACLK),
      .clr_i      (clr),
      .in_valid_i (accept),
      .in_data_i  (WRITE_DATA),
      .s1_valid_o (s1_valid),
      .s2_valid_o (s2_valid),
      .sum_o      (sum)
   );

   assign vld        = {s1_valid, s2_valid};
   assign COUNT_BUSY = vld.s1 | vld.s2;

   // One extra bit on the adder exposes the carry out of COUNT.
   always_comb begin
      count_d = count_q;
      words_d = words_q;
      ovf_d   = ovf_q;
      add_w   = {1'b0, count_q} + {{(ACC_W + 1 - SUM_W){1'b0}}, sum};
      if (vld.s2) begin
         words_d = words_q + 1'b1;
         count_d = add_w[ACC_W-1:0];
         if (add_w[ACC_W]) begin
            ovf_d = 1'b1;
`ifdef POPCOUNT_SAT_EN
            count_d = '1;
`else
            count_d = add_w[ACC_W-1:0];
`endif
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (clr) begin
         count_q <= '0;
         words_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         words_q <= words_d;
         ovf_q   <= ovf_d;
      end
   end

   assign COUNT    = count_q;
   assign WORDS    = words_q;
   assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_popcount_pipe.sv
// Bench for popcount_pipe: a 64-bit/32-bit-acc instance and a 32-bit/6-bit-acc instance share stimulus.
module tb_popcount_pipe;

   logic        ACLK        = 1'b0;
   logic        ARESET      = 1'b1;
   logic        WRITE_VALID = 1'b0;
   logic        COUNT_RST   = 1'b0;
   logic [63:0] WRITE_DATA  = '0;

   logic        rdy_a, rdy_b, ovf_a, ovf_b, busy_a, busy_b;
   logic [31:0] cnt_a, words_a;
   logic [5:0]  cnt_b, words_b;

   int checks   = 0;
   int failures = 0;

   always #5 ACLK = ~ACLK;

   popcount_pipe #(.DATA_W(64), .ACC_W(32)) dut_a (
      .ACLK        (ACLK),
      .ARESET      (ARESET),
      .WRITE_DATA  (WRITE_DATA),
      .WRITE_VALID (WRITE_VALID),
      .WRITE_READY (rdy_a),
      .COUNT_RST   (COUNT_RST),
      .COUNT       (cnt_a),
      .WORDS       (words_a),
      .OVERFLOW    (ovf_a),
      .COUNT_BUSY  (busy_a)
   );

   popcount_pipe #(.DATA_W(32), .ACC_W(6)) dut_b (
      .ACLK        (ACLK),
      .ARESET      (ARESET),
      .WRITE_DATA  (WRITE_DATA[31:0]),
      .WRITE_VALID (WRITE_VALID),
      .WRITE_READY (rdy_b),
      .COUNT_RST   (COUNT_RST),
      .COUNT       (cnt_b),
      .WORDS       (words_b),
      .OVERFLOW    (ovf_b),
      .COUNT_BUSY  (busy_b)
   );

`ifdef POPCOUNT_SAT_EN
   localparam bit     SAT     = 1'b1;
   localparam longint EXP_B37 = 63;
`else
   localparam bit     SAT     = 1'b0;
   localparam longint EXP_B37 = 32;
`endif
   localparam longint LIM_A = 64'h1_0000_0000;
   localparam longint LIM_B = 64;

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // Reference model: each accepted word's popcount lands two edges after acceptance.
   longint m_cnt [2];
   longint m_words [2];
   bit     m_ovf [2];
   longint edge_no = 0;
   longint due_q [$];
   int     pca_q [$];
   int     pcb_q [$];

   function automatic void apply(input int i, input int pc, input longint lim);
      longint tot;
      m_words[i] = (m_words[i] + 1) % lim;
      tot = m_cnt[i] + pc;
      if (tot >= lim) begin
         m_ovf[i] = 1'b1;
         m_cnt[i] = SAT ? lim - 1 : tot - lim;
      end else begin
         m_cnt[i] = tot;
      end
   endfunction

   always @(posedge ACLK) begin
      edge_no++;
      if (ARESET || COUNT_RST) begin
         for (int i = 0; i < 2; i++) begin
            m_cnt[i]   = 0;
            m_words[i] = 0;
            m_ovf[i]   = 1'b0;
         end
         due_q.delete();
         pca_q.delete();
         pcb_q.delete();
      end else begin
         while (due_q.size() > 0 && due_q[0] == edge_no) begin
            apply(0, pca_q[0], LIM_A);
            apply(1, pcb_q[0], LIM_B);
            void'(due_q.pop_front());
            void'(pca_q.pop_front());
            void'(pcb_q.pop_front());
         end
         if (WRITE_VALID) begin
            due_q.push_back(edge_no + 2);
            pca_q.push_back($countones(WRITE_DATA));
            pcb_q.push_back($countones(WRITE_DATA[31:0]));
         end
      end
   end

   always @(negedge ACLK) begin
      check("cnt_a",   cnt_a,   m_cnt[0]);
      check("words_a", words_a, m_words[0]);
      check("ovf_a",   ovf_a,   m_ovf[0]);
      check("busy_a",  busy_a,  due_q.size() != 0);
      check("rdy_a",   rdy_a,   !(ARESET || COUNT_RST));
      check("cnt_b",   cnt_b,   m_cnt[1]);
      check("words_b", words_b, m_words[1]);
      check("ovf_b",   ovf_b,   m_ovf[1]);
      check("busy_b",  busy_b,  due_q.size() != 0);
      check("rdy_b",   rdy_b,   !(ARESET || COUNT_RST));
   end

   task automatic step();
      @(negedge ACLK);
      #1;
   endtask

   task automatic put(input logic [63:0] d, input logic v);
      WRITE_DATA  = d;
      WRITE_VALID = v;
      step();
   endtask

   logic [63:0] vec [6] = '{64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000, 64'h1,
                            64'h8000_0000_0000_0000, 64'hF0F0_F0F0_0F0F_0F0F, 64'h0};

   initial begin
      step();
      check("rst_ready_a", rdy_a, 0);
      check("rst_cnt_a", cnt_a, 0);
      check("rst_busy_a", busy_a, 0);
      check("rst_ovf_b", ovf_b, 0);
      step();
      ARESET = 1'b0;
      #1;
      check("rel_ready_a", rdy_a, 1);
      check("rel_ready_b", rdy_b, 1);

      // Single all-ones word: busy for two cycles, then COUNT=32.
      put(64'hFFFF_FFFF, 1'b1);
      WRITE_VALID = 1'b0;
      check("s34_busy0", busy_a, 1);
      check("s34_cnt0", cnt_a, 0);
      step();
      check("s34_busy1", busy_a, 1);
      step();
      check("s34_cnt_a", cnt_a, 32);
      check("s34_words_a", words_a, 1);
      check("s34_busy2", busy_a, 0);
      check("s34_cnt_b", cnt_b, 32);

      // Back-to-back words including an all-zero word.
      COUNT_RST = 1'b1;
      #1;
      check("crst_ready_a", rdy_a, 0);
      step();
      COUNT_RST = 1'b0;
      put(64'h0000_000F, 1'b1);
      put(64'h8000_0001, 1'b1);
      put(64'h0000_0000, 1'b1);
      WRITE_VALID = 1'b0;
      check("s35_cnt1", cnt_a, 4);
      check("s35_words1", words_a, 1);
      step();
      check("s35_cnt2", cnt_a, 6);
      check("s35_words2", words_a, 2);
      step();
      check("s35_cnt3", cnt_a, 6);
      check("s35_words3", words_a, 3);

      // Clear with two words in flight and a word offered during the clear.
      put(64'h0000_00FF, 1'b1);
      put(64'h0000_FF00, 1'b1);
      WRITE_DATA = 64'hFFFF;
      COUNT_RST  = 1'b1;
      #1;
      check("s36_ready", rdy_a, 0);
      step();
      COUNT_RST   = 1'b0;
      WRITE_VALID = 1'b0;
      check("s36_cnt", cnt_a, 0);
      check("s36_words", words_a, 0);
      check("s36_busy", busy_a, 0);
      step();
      step();
      step();
      check("s36_cnt_late", cnt_a, 0);
      check("s36_words_late", words_a, 0);

      // Overflow on the 6-bit accumulator.
      put(64'hFFFF_FFFF, 1'b1);
      put(64'hFFFF_FFFF, 1'b1);
      put(64'hFFFF_FFFF, 1'b1);
      WRITE_VALID = 1'b0;
      step();
      step();
      check("s37_ovf_b", ovf_b, 1);
      check("s37_cnt_b", cnt_b, EXP_B37);
      check("s37_cnt_a", cnt_a, 96);
      check("s37_ovf_a", ovf_a, 0);
      put(64'h0, 1'b1);
      WRITE_VALID = 1'b0;
      step();
      step();
      check("s37_ovf_sticky", ovf_b, 1);
      check("s37_cnt_hold", cnt_b, EXP_B37);
      check("s37_words_b", words_b, 4);

      // WORDS wraps without touching OVERFLOW.
      COUNT_RST = 1'b1;
      step();
      COUNT_RST = 1'b0;
      check("clr_ovf_b", ovf_b, 0);
      for (int i = 0; i < 70; i++) begin
         put(64'h0, 1'b1);
      end
      WRITE_VALID = 1'b0;
      step();
      step();
      check("wrap_words_b", words_b, 6);
      check("wrap_words_a", words_a, 70);
      check("wrap_cnt_b", cnt_b, 0);
      check("wrap_ovf_b", ovf_b, 0);

      // 64-bit alternating pattern, then reset mid-stream.
      put(64'hAAAA_AAAA_AAAA_AAAA, 1'b1);
      WRITE_VALID = 1'b0;
      step();
      step();
      check("s38_cnt_a", cnt_a, 32);
      check("s38_cnt_b", cnt_b, 16);
      put(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      put(64'h1, 1'b1);
      ARESET = 1'b1;
      #1;
      check("s38_rst_ready", rdy_a, 0);
      step();
      check("s38_cnt", cnt_a, 0);
      check("s38_words", words_a, 0);
      check("s38_busy", busy_a, 0);
      check("s38_ovf", ovf_a, 0);
      ARESET      = 1'b0;
      WRITE_VALID = 1'b0;
      #1;
      check("s38_rel_ready", rdy_a, 1);
      step();
      step();
      step();
      check("s38_cnt_late", cnt_a, 0);

      // Mixed back-to-back vectors checked by the model each cycle.
      for (int i = 0; i < 6; i++) begin
         put(vec[i], 1'b1);
      end
      WRITE_VALID = 1'b0;
      step();
      step();
      check("mix_cnt_a", cnt_a, 32 + 32 + 1 + 1 + 32);
      check("mix_words_a", words_a, 6);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
